ia_packet_rx: RTL and testbench

//  Input assembler between the UART receiver and the top-level scene register file.

---
 rtl/ia_packet_rx_if.sv | 23 ++
 rtl/ia_packet_rx.sv | 140 ++++++++++++++
 tb/tb_ia_packet_rx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ia_packet_rx_if.sv
// Byte-stream and scene-update signals between the UART receiver, the packet
// assembler and the register-file write decoder.
interface ia_packet_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [5:0] idx;
   logic       update_reg;
   logic       pc_ready;
   logic       busy;
   logic       err_csum;
   logic       err_timeout;

   // master: the byte source side; slave: the packet assembler
   modport master (
      output rx_data, rx_valid,
      input  idx, update_reg, pc_ready, busy, err_csum, err_timeout
   );

   modport slave (
      input  rx_data, rx_valid,
      output idx, update_reg, pc_ready, busy, err_csum, err_timeout
   );
endinterface

// File: rtl/ia_packet_rx.sv
// Frames the UART byte stream into scene packets: SYNC, N_BYTES payload bytes
// (each strobed out with its index), then an 8-bit additive checksum.
module ia_packet_rx #(
   parameter int         N_BYTES     = 55,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter int         TO_W        = 20
) (
   input  logic          clk,
   input  logic          reset,
   ia_packet_rx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

   localparam logic [5:0]      LAST_IDX  = 6'(N_BYTES - 1);
   localparam logic [TO_W-1:0] TIMER_MAX = TO_W'(TIMEOUT_CYC - 1);

   state_t          state, state_next;
   logic [5:0]      cnt, cnt_next;
   logic [7:0]      sum, sum_next;
   logic [TO_W-1:0] timer, timer_next;

   logic [5:0] idx_q, idx_next;
   logic       update_q, update_next;
   logic       pc_ready_q, pc_ready_next;
   logic       busy_q, busy_next;
   logic       err_csum_q, err_csum_next;
   logic       err_timeout_q, err_timeout_next;

   logic sync_hit;
   logic timed_out;

   assign sync_hit  = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
   // An arriving byte always beats an expiring timer.
   assign timed_out = !bus.rx_valid && (timer == TIMER_MAX);

   // State and all registered outputs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         sum           <= '0;
         timer         <= '0;
         idx_q         <= '0;
         update_q      <= 1'b0;
         pc_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_csum_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         sum           <= sum_next;
         timer         <= timer_next;
         idx_q         <= idx_next;
         update_q      <= update_next;
         pc_ready_q    <= pc_ready_next;
         busy_q        <= busy_next;
         err_csum_q    <= err_csum_next;
         err_timeout_q <= err_timeout_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (sync_hit) state_next = PAYLOAD;
         end
         PAYLOAD: begin
            if (bus.rx_valid) begin
               if (cnt == LAST_IDX) state_next = CHECK;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         CHECK: begin
            if (bus.rx_valid || timed_out) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      // NOTE: every comb-assigned signal gets a default first, so no path can infer a latch.
      cnt_next         = cnt;
      sum_next         = sum;
      timer_next       = '0;
      idx_next         = idx_q;
      update_next      = 1'b0;
      pc_ready_next    = 1'b0;
      err_csum_next    = 1'b0;
      err_timeout_next = 1'b0;
      busy_next        = (state_next != IDLE);

      unique case (state)
         IDLE: begin
            if (sync_hit) begin
               cnt_next = '0;
               sum_next = '0;
            end
         end
         PAYLOAD: begin
            if (bus.rx_valid) begin
               update_next = 1'b1;
               idx_next    = cnt;
               sum_next    = sum + bus.rx_data;
               cnt_next    = cnt + 6'd1;
            end else if (timed_out) begin
               err_timeout_next = 1'b1;
            end else begin
               timer_next = timer + TO_W'(1);
            end
         end
         CHECK: begin
            if (bus.rx_valid) begin
               pc_ready_next = (bus.rx_data == sum);
               err_csum_next = (bus.rx_data != sum);
            end else if (timed_out) begin
               err_timeout_next = 1'b1;
            end else begin
               timer_next = timer + TO_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.idx         = idx_q;
   assign bus.update_reg  = update_q;
   assign bus.pc_ready    = pc_ready_q;
   assign bus.busy        = busy_q;
   assign bus.err_csum    = err_csum_q;
   assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ia_packet_rx.sv
// Self-checking bench for ia_packet_rx: packet-level vector table, corner-case
// sequences and a cycle-by-cycle reference model fed by random traffic.
module tb_ia_packet_rx;

   localparam int         N_BYTES = 55;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         TO_CYC  = 100;
   localparam int         TO_W    = 8;

   typedef enum int {PAT_RAMP, PAT_SYNC_IN, PAT_RAND} pat_t;

   typedef struct {
      string name;
      bit    garbage;
      pat_t  pat;
      bit    bad_csum;
      int    gap;       // idle cycles between bytes; -1 = random 0..2
      int    exp_upd;
      int    exp_pc;
      int    exp_csum;
      int    exp_to;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   ia_packet_rx_if bus ();

   ia_packet_rx #(
      .N_BYTES    (N_BYTES),
      .SYNC_BYTE  (SYNC),
      .TIMEOUT_CYC(TO_CYC),
      .TO_W       (TO_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int         n_upd = 0, n_pc = 0, n_csum = 0, n_to = 0;
   logic [5:0] idx_q[$];
   bit         mon_en = 1'b0;
   logic [7:0] payload[N_BYTES];

   // Reference model state: packet-level view of the byte stream
   bit         m_active = 1'b0;
   int         m_got = 0, m_sum = 0, m_idle = 0;
   logic [5:0] exp_idx = '0;
   bit         exp_upd = 1'b0, exp_pc = 1'b0, exp_busy = 1'b0, exp_csum = 1'b0, exp_to = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] dut_out();
      return {bus.idx, bus.update_reg, bus.pc_ready, bus.busy, bus.err_csum, bus.err_timeout};
   endfunction

   // Model: after SYNC, the first N_BYTES bytes are data, the next is the checksum;
   // TO_CYC consecutive byte-less cycles inside a packet abort it.
   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_active = 0; m_got = 0; m_sum = 0; m_idle = 0;
         exp_idx = '0; exp_upd = 0; exp_pc = 0; exp_busy = 0; exp_csum = 0; exp_to = 0;
      end else begin
         exp_upd = 0; exp_pc = 0; exp_csum = 0; exp_to = 0;
         if (!m_active) begin
            if (bus.rx_valid && bus.rx_data == SYNC) begin
               m_active = 1; m_got = 0; m_sum = 0; m_idle = 0;
            end
         end else if (bus.rx_valid) begin
            m_idle = 0;
            if (m_got < N_BYTES) begin
               exp_upd = 1;
               exp_idx = 6'(m_got);
               m_sum   = (m_sum + int'(bus.rx_data)) % 256;
               m_got++;
            end else begin
               if (int'(bus.rx_data) == m_sum) exp_pc = 1;
               else                            exp_csum = 1;
               m_active = 0;
            end
         end else if (m_idle == TO_CYC - 1) begin
            exp_to   = 1;
            m_active = 0;
            m_idle   = 0;
         end else begin
            m_idle++;
         end
         exp_busy = m_active;
      end
   end

   // Monitor: compare every cycle against the model and tally events
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("cycle_outputs", 32'(dut_out()),
               32'({exp_idx, exp_upd, exp_pc, exp_busy, exp_csum, exp_to}));
         if (bus.update_reg) begin
            n_upd++;
            idx_q.push_back(bus.idx);
         end
         if (bus.pc_ready)    n_pc++;
         if (bus.err_csum)    n_csum++;
         if (bus.err_timeout) n_to++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic int pick_gap(input int g);
      return (g < 0) ? int'($urandom_range(0, 2)) : g;
   endfunction

   task automatic build_payload(input pat_t pat);
      for (int k = 0; k < N_BYTES; k++) begin
         case (pat)
            PAT_RAMP:    payload[k] = 8'(k);
            PAT_SYNC_IN: payload[k] = (k == 5 || k == 6 || k == 40) ? SYNC : 8'(k);
            default:     payload[k] = 8'($urandom_range(0, 255));
         endcase
      end
   endtask

   function automatic logic [7:0] good_csum();
      int s = 0;
      for (int k = 0; k < N_BYTES; k++) s += int'(payload[k]);
      return 8'(s % 256);
   endfunction

   // Called at a negedge; returns at a negedge with rx_valid low
   task automatic send_byte(input logic [7:0] d, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_packet(input logic [7:0] csum, input int gap);
      send_byte(SYNC, pick_gap(gap));
      for (int k = 0; k < N_BYTES; k++) send_byte(payload[k], pick_gap(gap));
      send_byte(csum, pick_gap(gap));
   endtask

   task automatic check_idx_order(input string name);
      int bad = 0;
      foreach (idx_q[i]) if (int'(idx_q[i]) != i) bad++;
      check(name, bad, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int u0 = n_upd, p0 = n_pc, c0 = n_csum, t0 = n_to;
      logic [7:0] cs;
      idx_q.delete();
      if (v.garbage) begin
         send_byte(8'h00, 1);
         send_byte(8'hFF, 0);
         send_byte(8'h5A, 2);
      end
      build_payload(v.pat);
      cs = good_csum();
      if (v.bad_csum) cs = cs + 8'd1;
      send_packet(cs, v.gap);
      repeat (3) @(negedge clk);
      check({v.name, "_updates"}, n_upd - u0, v.exp_upd);
      check({v.name, "_pc_ready"}, n_pc - p0, v.exp_pc);
      check({v.name, "_err_csum"}, n_csum - c0, v.exp_csum);
      check({v.name, "_err_timeout"}, n_to - t0, v.exp_to);
      check_idx_order({v.name, "_idx_order"});
      check({v.name, "_busy_after"}, bus.busy, 0);
   endtask

   vec_t vecs[7];

   initial begin
      int u0, p0, t0, lat;

      vecs[0] = '{"good_ramp",    0, PAT_RAMP,    0,  1, N_BYTES, 1, 0, 0};
      vecs[1] = '{"bad_csum",     0, PAT_RAMP,    1,  1, N_BYTES, 0, 1, 0};
      vecs[2] = '{"garbage_sync", 1, PAT_RAMP,    0,  0, N_BYTES, 1, 0, 0};
      vecs[3] = '{"sync_in_data", 0, PAT_SYNC_IN, 0,  0, N_BYTES, 1, 0, 0};
      vecs[4] = '{"rand_good",    0, PAT_RAND,    0, -1, N_BYTES, 1, 0, 0};
      vecs[5] = '{"rand_bad",     1, PAT_RAND,    1, -1, N_BYTES, 0, 1, 0};
      vecs[6] = '{"rand_b2b",     0, PAT_RAND,    0,  0, N_BYTES, 1, 0, 0};

      reset        = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_state", 32'(dut_out()), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) run_vec(vecs[v]);

      // Inter-byte timeout: the timer holds TO_CYC-1 in the last quiet cycle
      u0 = n_upd; t0 = n_to; p0 = n_pc;
      send_byte(SYNC, 0);
      for (int k = 0; k < 10; k++) send_byte(8'(k), 0);
      lat = -1;
      for (int i = 1; i <= TO_CYC + 20; i++) begin
         @(negedge clk);
         if (bus.err_timeout) begin
            lat = i;
            break;
         end
      end
      check("timeout_latency", lat, TO_CYC);
      check("timeout_busy", bus.busy, 0);
      check("timeout_updates", n_upd - u0, 10);
      repeat (2) @(negedge clk);
      check("timeout_pulses", n_to - t0, 1);
      check("timeout_no_pc", n_pc - p0, 0);
      run_vec(vecs[0]);

      // Byte arriving in the very cycle the timer expires keeps the packet alive
      idx_q.delete();
      p0 = n_pc; t0 = n_to;
      build_payload(PAT_RAND);
      send_byte(SYNC, 0);
      for (int k = 0; k < N_BYTES; k++) send_byte(payload[k], (k == 2) ? TO_CYC - 1 : 0);
      send_byte(good_csum(), 0);
      repeat (3) @(negedge clk);
      check("edge_timeout_none", n_to - t0, 0);
      check("edge_timeout_pc", n_pc - p0, 1);
      check_idx_order("edge_timeout_idx_order");

      // Reset coinciding with payload byte 30
      u0 = n_upd;
      build_payload(PAT_RAMP);
      send_byte(SYNC, 1);
      for (int k = 0; k < 30; k++) send_byte(payload[k], 1);
      bus.rx_valid = 1'b1;
      bus.rx_data  = payload[30];
      reset        = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("reset_mid_outputs", 32'(dut_out()), 0);
      check("reset_mid_updates", n_upd - u0, 30);
      reset = 1'b0;
      @(negedge clk);
      run_vec(vecs[0]);

      // Random packets with random garbage, gaps and checksum errors
      for (int r = 0; r < 4; r++) begin
         int   c0, ng;
         bit   bad;
         logic [7:0] g;
         p0 = n_pc; c0 = n_csum;
         bad = 1'($urandom_range(0, 1));
         ng  = int'($urandom_range(0, 2));
         for (int j = 0; j < ng; j++) begin
            g = 8'($urandom_range(0, 255));
            if (g == SYNC) g = 8'h00;
            send_byte(g, pick_gap(-1));
         end
         build_payload(PAT_RAND);
         send_packet(bad ? good_csum() ^ 8'h40 : good_csum(), -1);
         repeat (3) @(negedge clk);
         check("rand_pc_ready", n_pc - p0, bad ? 0 : 1);
         check("rand_err_csum", n_csum - c0, bad ? 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
